// File: rtl/iir_pkg.sv
// Shared constants and types for the serial IIR low-pass sections.
//   TAPS/DW/CW/OW : tap count and signed datapath widths
//   NUM_COE       : numerator (zero-section) coefficients, packed TAPS*CW,
//                   COE[0] in the lowest slice applies to x[n]
//   state_t       : serial-section FSM encoding (IDLE/MAC/DONE)
package iir_pkg;

  localparam int TAPS  = 8;
  localparam int DW    = 12;
  localparam int CW    = 12;
  localparam int OW    = 26;
  localparam int CNT_W = $clog2(TAPS + 1);
  localparam int IDX_W = $clog2(TAPS);

  // Binomial numerator, written k=7 down to k=0 so COE[0] lands in bits [CW-1:0].
  localparam logic [TAPS*CW-1:0] NUM_COE = {
    12'sd1, 12'sd7, 12'sd21, 12'sd35, 12'sd35, 12'sd21, 12'sd7, 12'sd1
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/iir_serial_mac.sv
// Shared serial multiply-accumulate: registered signed multiplier followed by
// an ACC_W-bit accumulator. A product loaded while en is high is added into
// acc on the following cycle.
//   clk, rst : clock, synchronous active-high reset (clears acc)
//   clr      : start of a new sum; clears acc and any pending product
//   en       : load a*b into the product register this cycle
//   a, b     : signed multiplier operands
//   acc      : signed running sum
module iir_serial_mac #(
  parameter int DATA_W = 12,
  parameter int COEF_W = 12,
  parameter int ACC_W  = 26
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  // Full-width product so the block stays correct for any operand values.
  localparam int PW = DATA_W + COEF_W;

  logic signed [PW-1:0] prod_p1;
  logic                 vld_p1;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [PW-1:0] p);
    return ACC_W'(p);
  endfunction

  // ---- stage 1: registered product ----
  always_ff @(posedge clk) begin
    if (en) prod_p1 <= a * b;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) vld_p1 <= 1'b0;
    else            vld_p1 <= en;
  end

  // ---- stage 2: accumulate ----
  always_ff @(posedge clk) begin
    if (rst || clr)  acc <= '0;
    else if (vld_p1) acc <= acc + sext(prod_p1);
  end

endmodule

// File: rtl/iir_zero_serial.sv
// Zero (feed-forward) section of the 7th-order IIR low-pass:
//   Xout = sum_{k=0..TAPS-1} COE[k] * x[n-k]
// computed serially on one shared multiplier. One result per accepted sample,
// 11 clocks per sample; the /512 scaling lives in the summing node downstream.
//   clk, rst  : clock, synchronous active-high reset (aborts any computation)
//   Xin       : signed input sample, taken when in_valid is high and idle
//   in_valid  : one-cycle sample strobe
//   Xout      : signed sum, held between results
//   out_valid : one-cycle strobe, Xout updated
//   busy      : a sample is being processed
//   overrun   : sticky, a sample arrived while busy and was dropped
module iir_zero_serial
  import iir_pkg::*;
#(
  parameter logic [TAPS*CW-1:0] COE = NUM_COE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] Xin,
  input  logic                 in_valid,
  output logic signed [OW-1:0] Xout,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 overrun
);

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic signed [DW-1:0]   x_dl [TAPS];
  logic                   start;
  logic                   mac_en;
  logic signed [DW-1:0]   tap_x;
  logic signed [CW-1:0]   tap_c;
  logic signed [OW-1:0]   acc;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        start     = 1'b1;
        state_nxt = MAC;
      end
      MAC:  if (cnt == CNT_W'(TAPS)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  // cnt == TAPS is the flush cycle: nothing new is multiplied, the last
  // product is still being accumulated.
  assign mac_en = (state == MAC) && (cnt < CNT_W'(TAPS));
  assign tap_x  = x_dl[cnt[IDX_W-1:0]];
  assign tap_c  = COE[cnt[IDX_W-1:0]*CW +: CW];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (start)         cnt <= '0;
    else if (state == MAC)  cnt <= cnt + 1'b1;
  end

  // ---- stage 0: delay line, shifted only when a sample is accepted ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) x_dl[k] <= '0;
    end else if (start) begin
      for (int k = TAPS - 1; k > 0; k--) x_dl[k] <= x_dl[k-1];
      x_dl[0] <= Xin;
    end
  end

  // ---- stages 1-2: shared multiply-accumulate ----
  iir_serial_mac #(
    .DATA_W (DW),
    .COEF_W (CW),
    .ACC_W  (OW)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .en  (mac_en),
    .a   (tap_x),
    .b   (tap_c),
    .acc (acc)
  );

  // ---- output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      Xout      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state == DONE);
      if (state == DONE) Xout <= acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                   overrun <= 1'b0;
    else if (in_valid && busy) overrun <= 1'b1;
  end

endmodule

// File: tb/tb_iir_zero_serial.sv
module tb_iir_zero_serial;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [11:0] Xin;
  logic               in_valid;
  logic signed [25:0] Xout;
  logic               out_valid;
  logic               busy;
  logic               overrun;

  iir_zero_serial dut (
    .clk       (clk),
    .rst       (rst),
    .Xin       (Xin),
    .in_valid  (in_valid),
    .Xout      (Xout),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int sb[$];
  int mdl[8];
  int cf[8] = '{1, 7, 21, 35, 35, 21, 7, 1};

  typedef struct {
    int x;
    int exp;
  } vec_t;
  vec_t tbl[25];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_shift(input int x);
    int s = 0;
    for (int k = 7; k > 0; k--) mdl[k] = mdl[k-1];
    mdl[0] = x;
    for (int k = 0; k < 8; k++) s += cf[k] * mdl[k];
    return s;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 8; k++) mdl[k] = 0;
  endtask

  // Drives one strobe; returns #1 after the edge that samples it (E0).
  task automatic send(input int x, input int exp, input bit push);
    @(negedge clk);
    Xin      = 12'(x);
    in_valid = 1'b1;
    if (push) sb.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait_busy", int'(busy), 0);
  endtask

  task automatic no_out(input int n);
    int seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_out_valid", seen, 0);
  endtask

  // Scoreboard: every out_valid pops the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out_valid: got Xout=%0d, expected no result", Xout);
      end else begin
        check("xout", int'(Xout), sb.pop_front());
      end
    end
  end

  initial begin
    // impulse of 100 then zeros
    tbl[0] = '{100, 100};   tbl[1] = '{0, 700};     tbl[2] = '{0, 2100};
    tbl[3] = '{0, 3500};    tbl[4] = '{0, 3500};    tbl[5] = '{0, 2100};
    tbl[6] = '{0, 700};     tbl[7] = '{0, 100};     tbl[8] = '{0, 0};
    // negative full-scale step from an empty delay line
    tbl[9]  = '{-2048, -2048};    tbl[10] = '{-2048, -16384};
    tbl[11] = '{-2048, -59392};   tbl[12] = '{-2048, -131072};
    tbl[13] = '{-2048, -202752};  tbl[14] = '{-2048, -245760};
    tbl[15] = '{-2048, -260096};  tbl[16] = '{-2048, -262144};
    // swing to positive full scale
    tbl[17] = '{2047, -258049};   tbl[18] = '{2047, -229384};
    tbl[19] = '{2047, -143389};   tbl[20] = '{2047, -64};
    tbl[21] = '{2047, 143261};    tbl[22] = '{2047, 229256};
    tbl[23] = '{2047, 257921};    tbl[24] = '{2047, 262016};

    model_clear();
    rst      = 1'b1;
    in_valid = 1'b0;
    Xin      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_xout", int'(Xout), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    rst = 1'b0;

    // impulse and full-scale step vectors
    for (int i = 0; i < 25; i++) begin
      void'(model_shift(tbl[i].x));
      send(tbl[i].x, tbl[i].exp, 1'b1);
      repeat (15) @(posedge clk);
    end

    // latency and back-to-back acceptance at E11
    wait_idle();
    send(77, model_shift(77), 1'b1);
    check("busy_after_e0", int'(busy), 1);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 9)  check("out_valid_e9", int'(out_valid), 0);
      if (i == 10) check("out_valid_e10", int'(out_valid), 1);
    end
    Xin      = -12'sd5;
    in_valid = 1'b1;
    sb.push_back(model_shift(-5));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("e11_busy", int'(busy), 1);
    check("e11_overrun", int'(overrun), 0);

    // overrun: strobe at E5 dropped
    wait_idle();
    send(400, model_shift(400), 1'b1);
    repeat (4) @(posedge clk);
    #1;
    Xin      = 12'sd999;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("overrun_set", int'(overrun), 1);
    repeat (15) @(posedge clk);
    send(-30, model_shift(-30), 1'b1);
    repeat (15) @(posedge clk);
    check("overrun_sticky", int'(overrun), 1);

    // reset held 3 cycles in the middle of a computation
    wait_idle();
    send(123, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_xout", int'(Xout), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_overrun", int'(overrun), 0);
    rst = 1'b0;
    model_clear();
    no_out(15);

    // abort at E4, then an impulse sees a cleared delay line
    send(300, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    no_out(15);
    model_clear();
    send(50, model_shift(50), 1'b1);
    repeat (15) @(posedge clk);

    begin
      int n = 0;
      while (sb.size() != 0 && n < 30) begin
        @(posedge clk);
        n++;
      end
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
